fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter IMEM_AW, default 8, word-address width of instruction memory.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, prefetch buffer entries; power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  read request to instruction memory this cycle.
REQ-006 imem_addr  output  IMEM_AW  word address; equals fetch PC[IMEM_AW+1:2].
REQ-007 imem_rdata  input  32  read data; valid exactly one cycle after imem_req.
REQ-008 redirect_valid  input  1  downstream control-flow redirect.
REQ-009 redirect_pc  input  32  redirect byte address; bits [1:0] ignored, treated as 0.
REQ-010 inst_valid  output  1  inst/inst_pc valid toward decode.
REQ-011 inst  output  32  instruction word at FIFO head.
REQ-012 inst_pc  output  32  byte address of inst.
REQ-013 inst_ready  input  1  decode accepts; transfer when inst_valid && inst_ready.

Function
REQ-014 Fetch PC SHALL be a 32-bit byte address, incremented by 4 per issued request.
REQ-015 imem_req SHALL assert only when (FIFO count + in-flight count) < FIFO_DEPTH; at most one request in flight.
REQ-016 Response SHALL be pushed with its PC at the end of the cycle after the request; inst_valid SHALL assert the following cycle (2-cycle request-to-valid latency).
REQ-017 FIFO SHALL be in-order; pop on inst_valid && inst_ready; simultaneous push and pop SHALL keep count unchanged.
REQ-018 Full FIFO: imem_req SHALL stay low, no instruction lost or duplicated; empty FIFO: inst_valid low, inst/inst_pc don't-care.
REQ-019 Steady state with inst_ready held high SHALL sustain one instruction per cycle.
REQ-020 redirect_valid SHALL, that cycle: flush FIFO, discard any in-flight response, set fetch PC to {redirect_pc[31:2],2'b00}; first new imem_req the next cycle.
REQ-021 Redirect concurrent with a pop SHALL win; the popped instruction is still considered delivered, nothing else is.
REQ-022 Redirect concurrent with arriving response SHALL drop that response.
REQ-023 Fetch PC wrap from 0xFFFFFFFC SHALL roll to 0x00000000.

Reset
REQ-024 On reset: fetch PC 0, FIFO empty, no request in flight, imem_req 0, inst_valid 0, inst 0, inst_pc 0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered and in-flight data; first imem_req (addr 0) in the first cycle after reset deasserts.
REQ-026 Reset SHALL take priority over redirect_valid.

Configuration
REQ-027 Macro FETCH_JUMP_PREDECODE_EN SHALL, when defined, predecode pushed words with opcode [31:26]=6'b000010: target = inst_pc + (sign-extended [25:0] << 2).
REQ-028 With FETCH_JUMP_PREDECODE_EN: the JUMP is still delivered to decode; any request issued in the push cycle is cancelled; fetch PC = target; next imem_req the following cycle; redirect_valid overrides predecode in the same cycle.
REQ-029 Without FETCH_JUMP_PREDECODE_EN: purely sequential fetch; control flow changes only via redirect_valid.

Verification
REQ-030 Reset 2 cycles, release, inst_ready=1 -> imem_req addr 0 first cycle, inst_valid 2 cycles later, inst_pc 0x0,0x4,0x8... one per cycle.
REQ-031 imem[0..3]=0x00221800,0x04222000,0x8CA60004,0xACA60008 -> inst delivered in that order with inst_pc 0x0..0xC.
REQ-032 inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered, imem_req low, release -> contiguous inst_pc sequence, no gaps/duplicates.
REQ-033 redirect_valid with redirect_pc=0x43 while FIFO holds 3 entries and one in flight -> next delivered inst_pc 0x40, no stale entries.
REQ-034 imem[4]={6'b000010,26'd3}: with macro -> inst_pc after 0x10 is 0x1C; without -> 0x14.
REQ-035 Reset asserted with FIFO full and request in flight -> inst_valid 0 next cycle, then restart from addr 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, one-cycle-latency imem interface, in-order prefetch FIFO.
// Optional jump predecode on pushed words is enabled by defining FETCH_JUMP_PREDECODE_EN.
module fetch_unit #(
    parameter int unsigned IMEM_AW    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    input  logic               inst_ready
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW:0] DepthOcc = (CntW + 1)'(FIFO_DEPTH);

    logic [31:0]     pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]     data_q [FIFO_DEPTH];
    logic [31:0]     pcs_q  [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            jump_take;
    logic [31:0]     jump_target;
    logic [CntW:0]   occ;

    // Byte offset of a redirect is architecturally ignored.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        // A response is only kept if no redirect kills it in its arrival cycle.
        push = inflight_q && !redirect_valid;
        pop  = inst_valid && inst_ready;
        occ  = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
`ifdef FETCH_JUMP_PREDECODE_EN
        jump_take   = push && (imem_rdata[31:26] == 6'b000010);
        jump_target = req_pc_q + {{4{imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
`else
        jump_take   = 1'b0;
        jump_target = 32'd0;
`endif
        imem_req  = !reset && !redirect_valid && !jump_take && (occ < DepthOcc);
        imem_addr = pc_q[IMEM_AW+1:2];

        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (jump_take) begin
            pc_d = jump_target;
        end else if (imem_req) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        inflight_d = imem_req;
        req_pc_d   = imem_req ? pc_q : req_pc_q;

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= 32'd0;
            inflight_q <= 1'b0;
            req_pc_q   <= 32'd0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            pcs_q[wr_ptr_q]  <= req_pc_q;
        end
    end

    always_comb begin
        inst_valid = (count_q != '0);
        inst       = inst_valid ? data_q[rd_ptr_q] : 32'd0;
        inst_pc    = inst_valid ? pcs_q[rd_ptr_q] : 32'd0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC stream queued at reset/redirect, popped per transfer.
module tb_fetch_unit;

    localparam int unsigned IMEM_AW    = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               inst_valid;
    logic [31:0]        inst;
    logic [31:0]        inst_pc;
    logic               inst_ready;

    logic [31:0] imem [256];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_bad    = 0;
    int          reqs     = 0;
    int          xfers    = 0;
    logic [31:0] prev_pc  = 32'hFFFF_FFFF;
    logic [31:0] after10  = 32'hFFFF_FFFF;

    fetch_unit #(
        .IMEM_AW   (IMEM_AW),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    always #5 clk = ~clk;

    // One-cycle memory; garbage when not requested so stray pushes are visible.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem[imem_addr];
        else          imem_rdata <= $urandom();
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference program order from start, following jumps when predecode is built in.
    task automatic fill(input logic [31:0] start);
        logic [31:0] p;
        logic [31:0] w;
        logic [31:0] nxt;
        p = start;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(p);
            w   = imem[p[9:2]];
            nxt = p + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
            if (w[31:26] == 6'b000010) nxt = p + {{4{w[25]}}, w[25:0], 2'b00};
`endif
            p = nxt;
        end
    endtask

    task automatic cyc(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] e;
        @(negedge clk);
        reset          = rst;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (rst) begin
            reqs  = 0;
            xfers = 0;
            fill(32'd0);
        end else begin
            if (imem_req) reqs++;
            if (inst_valid && inst_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_xfer", inst_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_pc", inst_pc, e);
                    check_eq("sb_inst", inst, imem[e[9:2]]);
                end
                if (prev_pc == 32'h10) after10 = inst_pc;
                prev_pc = inst_pc;
            end
            if (rv) fill({rpc[31:2], 2'b00});
        end
    endtask

    initial begin
        int x0;
        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        for (int i = 0; i < 256; i++) imem[i] = {16'hA500, i[15:0]};
        imem[0] = 32'h0022_1800;
        imem[1] = 32'h0422_2000;
        imem[2] = 32'h8CA6_0004;
        imem[3] = 32'hACA6_0008;

        // Reset and first-fetch latency
        cyc(1, 1, 0, 0);
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        cyc(1, 1, 1, 32'h80);
        check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_inst_pc", inst_pc, 32'd0);
        cyc(0, 1, 0, 0);
        check_eq("first_req", {31'd0, imem_req}, 32'd1);
        check_eq("first_addr", {24'd0, imem_addr}, 32'd0);
        check_eq("lat_valid0", {31'd0, inst_valid}, 32'd0);
        cyc(0, 1, 0, 0);
        check_eq("lat_valid1", {31'd0, inst_valid}, 32'd0);
        cyc(0, 1, 0, 0);
        check_eq("lat_valid2", {31'd0, inst_valid}, 32'd1);
        check_eq("lat_pc", inst_pc, 32'd0);
        x0 = xfers;
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        check_eq("throughput", xfers - x0, 10);

        // Back-pressure fills the FIFO exactly
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        check_eq("full_req", {31'd0, imem_req}, 32'd0);
        check_eq("full_occ", reqs - xfers, FIFO_DEPTH);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0);

        // Redirect with 3 buffered and one in flight
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        check_eq("pre_redir_occ", reqs - xfers, 4);
        cyc(0, 0, 1, 32'h43);
        check_eq("redir_req", {31'd0, imem_req}, 32'd0);
        cyc(0, 1, 0, 0);
        check_eq("redir_next_req", {31'd0, imem_req}, 32'd1);
        check_eq("redir_addr", {24'd0, imem_addr}, 32'h10);
        check_eq("redir_flush", {31'd0, inst_valid}, 32'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check_eq("redir_pc", inst_pc, 32'h40);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
        // Redirect concurrent with a pop
        cyc(0, 1, 1, 32'h80);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);

        // PC wrap
        cyc(0, 1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);

        // Jump word at 0x10
        imem[4] = {6'b000010, 26'd3};
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        after10 = 32'hFFFF_FFFF;
        prev_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0);
`ifdef FETCH_JUMP_PREDECODE_EN
        check_eq("jump_next", after10, 32'h1C);
`else
        check_eq("jump_next", after10, 32'h14);
`endif

        // Reset mid-operation with a full FIFO
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        check_eq("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
        cyc(1, 0, 0, 0);
        check_eq("mid_rst_req", {31'd0, imem_req}, 32'd0);
        cyc(1, 0, 0, 0);
        check_eq("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        cyc(0, 1, 0, 0);
        check_eq("restart_req", {31'd0, imem_req}, 32'd1);
        check_eq("restart_addr", {24'd0, imem_addr}, 32'd0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        check_eq("restart_xfers", xfers, 9);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
